ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/rvx10_pkg.sv | 38 +++
 rtl/rvx10_alu.sv | 50 +++++
 rtl/ex_stage.sv | 142 ++++++++++++++
 tb/tb_ex_stage.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvx10_pkg.sv
// Shared RVX10 encodings: ALU operations, branch funct3 codes, forwarding selects.
package rvx10_pkg;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_SLT  = 5'd5,
    ALU_SLTU = 5'd6,
    ALU_SLL  = 5'd7,
    ALU_SRL  = 5'd8,
    ALU_SRA  = 5'd9,
    ALU_ANDN = 5'd10,
    ALU_ORN  = 5'd11,
    ALU_XNOR = 5'd12,
    ALU_MIN  = 5'd13,
    ALU_MAX  = 5'd14,
    ALU_MINU = 5'd15,
    ALU_MAXU = 5'd16,
    ALU_ROL  = 5'd17,
    ALU_ROR  = 5'd18,
    ALU_ABS  = 5'd19
  } alu_op_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] FWD_IDEX = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

endpackage

// File: rtl/rvx10_alu.sv
// Combinational RVX10 ALU: base RV32 ops plus bit-manip, min/max, rotate and abs.
// Unassigned operation codes produce zero.
module rvx10_alu
  import rvx10_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  alu_ctrl_i,
  output logic [31:0] result_o
);

  logic [4:0]  shamt;
  logic [5:0]  shamt_inv;
  logic        lt_s;
  logic        lt_u;

  assign shamt     = b_i[4:0];
  // a >> 32 evaluates to 0, so a rotate by zero falls out as a | 0
  assign shamt_inv = 6'd32 - {1'b0, shamt};
  assign lt_s      = $signed(a_i) < $signed(b_i);
  assign lt_u      = a_i < b_i;

  always_comb begin
    result_o = '0;
    case (alu_ctrl_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SLT:  result_o = {31'd0, lt_s};
      ALU_SLTU: result_o = {31'd0, lt_u};
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_ANDN: result_o = a_i & ~b_i;
      ALU_ORN:  result_o = a_i | ~b_i;
      ALU_XNOR: result_o = ~(a_i ^ b_i);
      ALU_MIN:  result_o = lt_s ? a_i : b_i;
      ALU_MAX:  result_o = lt_s ? b_i : a_i;
      ALU_MINU: result_o = lt_u ? a_i : b_i;
      ALU_MAXU: result_o = lt_u ? b_i : a_i;
      ALU_ROL:  result_o = (a_i << shamt) | (a_i >> shamt_inv);
      ALU_ROR:  result_o = (a_i >> shamt) | (a_i << shamt_inv);
      ALU_ABS:  result_o = a_i[31] ? (32'd0 - a_i) : a_i;
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and the EX/MEM register.
// PCSrc_E/PCTarget_E are combinational; M outputs follow one edge later (stall holds, flush bubbles).
module ex_stage
  import rvx10_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_E,
  input  logic [31:0] rd1_E,
  input  logic [31:0] rd2_E,
  input  logic [31:0] imm_E,
  input  logic [31:0] pc_E,
  input  logic [4:0]  rd_E,
  input  logic [4:0]  ALUCtrl_E,
  input  logic        ALUSrc_E,
  input  logic [2:0]  funct3_E,
  input  logic        RegWrite_E,
  input  logic        MemWrite_E,
  input  logic        Branch_E,
  input  logic        Jump_E,
  input  logic        Jalr_E,
  input  logic [1:0]  ResultSrc_E,
  input  logic [1:0]  FwdSel_A,
  input  logic [1:0]  FwdSel_B,
  input  logic [31:0] Result_W,
  input  logic        stall_M,
  input  logic        flush_M,
  output logic [31:0] ALUResult_M,
  output logic [31:0] WriteData_M,
  output logic [31:0] PCPlus4_M,
  output logic [4:0]  rd_M,
  output logic        RegWrite_M,
  output logic        MemWrite_M,
  output logic        valid_M,
  output logic [1:0]  ResultSrc_M,
  output logic        PCSrc_E,
  output logic [31:0] PCTarget_E
);

  logic [31:0] src_a, fwd_b, src_b, alu_y;
  logic        cond;

  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] write_data_q, write_data_d;
  logic [31:0] pc_plus4_q,   pc_plus4_d;
  logic [4:0]  rd_q,         rd_d;
  logic [1:0]  result_src_q, result_src_d;
  logic        valid_q,      valid_d;
  logic        reg_write_q,  reg_write_d;
  logic        mem_write_q,  mem_write_d;

  // MEM forwarding taps the register itself, so a stalled M stage forwards its held result
  always_comb begin
    case (FwdSel_A)
      FWD_WB:  src_a = Result_W;
      FWD_MEM: src_a = alu_result_q;
      default: src_a = rd1_E;
    endcase
    case (FwdSel_B)
      FWD_WB:  fwd_b = Result_W;
      FWD_MEM: fwd_b = alu_result_q;
      default: fwd_b = rd2_E;
    endcase
  end

  assign src_b = ALUSrc_E ? imm_E : fwd_b;

  rvx10_alu u_alu (
    .a_i        (src_a),
    .b_i        (src_b),
    .alu_ctrl_i (ALUCtrl_E),
    .result_o   (alu_y)
  );

  // Branches compare against the register operand even when ALUSrc selects the immediate
  always_comb begin
    case (funct3_E)
      F3_BEQ:  cond = (src_a == fwd_b);
      F3_BNE:  cond = (src_a != fwd_b);
      F3_BLT:  cond = ($signed(src_a) <  $signed(fwd_b));
      F3_BGE:  cond = ($signed(src_a) >= $signed(fwd_b));
      F3_BLTU: cond = (src_a <  fwd_b);
      F3_BGEU: cond = (src_a >= fwd_b);
      default: cond = 1'b0;
    endcase
  end

  assign PCSrc_E    = valid_E & (Jump_E | (Branch_E & cond));
  assign PCTarget_E = Jalr_E ? ((src_a + imm_E) & ~32'd1) : (pc_E + imm_E);

  always_comb begin
    alu_result_d = alu_y;
    write_data_d = fwd_b;
    pc_plus4_d   = pc_E + 32'd4;
    rd_d         = rd_E;
    result_src_d = ResultSrc_E;
    valid_d      = valid_E;
    reg_write_d  = RegWrite_E & valid_E;
    mem_write_d  = MemWrite_E & valid_E;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
      rd_q         <= '0;
      result_src_q <= '0;
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
    end else if (flush_M) begin
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
      rd_q         <= '0;
      result_src_q <= '0;
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
    end else if (!stall_M) begin
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_plus4_q   <= pc_plus4_d;
      rd_q         <= rd_d;
      result_src_q <= result_src_d;
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
    end
  end

  assign ALUResult_M = alu_result_q;
  assign WriteData_M = write_data_q;
  assign PCPlus4_M   = pc_plus4_q;
  assign rd_M        = rd_q;
  assign ResultSrc_M = result_src_q;
  assign valid_M     = valid_q;
  assign RegWrite_M  = reg_write_q;
  assign MemWrite_M  = mem_write_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_ex_stage;
  import rvx10_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid_E;
  logic [31:0] rd1_E, rd2_E, imm_E, pc_E, Result_W;
  logic [4:0]  rd_E, ALUCtrl_E;
  logic        ALUSrc_E;
  logic [2:0]  funct3_E;
  logic        RegWrite_E, MemWrite_E, Branch_E, Jump_E, Jalr_E;
  logic [1:0]  ResultSrc_E, FwdSel_A, FwdSel_B;
  logic        stall_M, flush_M;
  logic [31:0] ALUResult_M, WriteData_M, PCPlus4_M, PCTarget_E;
  logic [4:0]  rd_M;
  logic        RegWrite_M, MemWrite_M, valid_M, PCSrc_E;
  logic [1:0]  ResultSrc_M;

  int n_tests = 0;
  int n_fail  = 0;

  // model of the EX/MEM register contents
  logic [31:0] m_alu, m_wd, m_pc4;
  logic [4:0]  m_rd;
  logic [1:0]  m_rs;
  logic        m_valid, m_rw, m_mw;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n), .valid_E(valid_E), .rd1_E(rd1_E), .rd2_E(rd2_E),
    .imm_E(imm_E), .pc_E(pc_E), .rd_E(rd_E), .ALUCtrl_E(ALUCtrl_E), .ALUSrc_E(ALUSrc_E),
    .funct3_E(funct3_E), .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E),
    .Branch_E(Branch_E), .Jump_E(Jump_E), .Jalr_E(Jalr_E), .ResultSrc_E(ResultSrc_E),
    .FwdSel_A(FwdSel_A), .FwdSel_B(FwdSel_B), .Result_W(Result_W),
    .stall_M(stall_M), .flush_M(flush_M),
    .ALUResult_M(ALUResult_M), .WriteData_M(WriteData_M), .PCPlus4_M(PCPlus4_M),
    .rd_M(rd_M), .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M), .valid_M(valid_M),
    .ResultSrc_M(ResultSrc_M), .PCSrc_E(PCSrc_E), .PCTarget_E(PCTarget_E)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, n;
    logic [31:0] r;
    sa = a; sb = b; n = int'(b[4:0]); r = a;
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return (sa < sb) ? 32'd1 : 32'd0;
      6:  return (a < b) ? 32'd1 : 32'd0;
      7:  begin for (int i = 0; i < n; i++) r = {r[30:0], 1'b0}; return r; end
      8:  begin for (int i = 0; i < n; i++) r = {1'b0, r[31:1]}; return r; end
      9:  begin for (int i = 0; i < n; i++) r = {r[31], r[31:1]}; return r; end
      10: return a & ~b;
      11: return a | ~b;
      12: return ~(a ^ b);
      13: return (sa < sb) ? a : b;
      14: return (sa > sb) ? a : b;
      15: return (a < b) ? a : b;
      16: return (a > b) ? a : b;
      17: begin for (int i = 0; i < n; i++) r = {r[30:0], r[31]}; return r; end
      18: begin for (int i = 0; i < n; i++) r = {r[0], r[31:1]}; return r; end
      19: return (sa < 0) ? 32'(-sa) : a;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a; sb = b;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] idex);
    if (s == 2'd1) return Result_W;
    if (s == 2'd2) return m_alu;
    return idex;
  endfunction

  function automatic logic [31:0] exp_target();
    logic [31:0] a;
    a = pick(FwdSel_A, rd1_E);
    if (Jalr_E) return (a + imm_E) & 32'hFFFF_FFFE;
    return pc_E + imm_E;
  endfunction

  function automatic logic exp_pcsrc();
    return valid_E && (Jump_E || (Branch_E && ref_cond(funct3_E, pick(FwdSel_A, rd1_E), pick(FwdSel_B, rd2_E))));
  endfunction

  task automatic model_clear();
    m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0; m_rs = 0; m_valid = 0; m_rw = 0; m_mw = 0;
  endtask

  // advance one rising edge, updating the model from the pre-edge inputs; returns 1ns after edge
  task automatic tick();
    logic [31:0] a, fb, y;
    logic fl, st;
    a  = pick(FwdSel_A, rd1_E);
    fb = pick(FwdSel_B, rd2_E);
    y  = ref_alu(int'(ALUCtrl_E), a, ALUSrc_E ? imm_E : fb);
    fl = flush_M; st = stall_M;
    @(posedge clk);
    if (fl) model_clear();
    else if (!st) begin
      m_alu = y; m_wd = fb; m_pc4 = pc_E + 32'd4; m_rd = rd_E; m_rs = ResultSrc_E;
      m_valid = valid_E; m_rw = RegWrite_E & valid_E; m_mw = MemWrite_E & valid_E;
    end
    #1;
  endtask

  task automatic set_idle();
    valid_E = 0; rd1_E = 0; rd2_E = 0; imm_E = 0; pc_E = 0; rd_E = 0; ALUCtrl_E = 0;
    ALUSrc_E = 0; funct3_E = 0; RegWrite_E = 0; MemWrite_E = 0; Branch_E = 0; Jump_E = 0;
    Jalr_E = 0; ResultSrc_E = 0; FwdSel_A = 0; FwdSel_B = 0; Result_W = 0;
    stall_M = 0; flush_M = 0;
  endtask

  task automatic test_reset();
    set_idle();
    #1 rst_n = 0;
    #1;
    n_tests++;
    if ({ALUResult_M, WriteData_M, PCPlus4_M, rd_M, ResultSrc_M, valid_M, RegWrite_M, MemWrite_M} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: alu=%h wd=%h pc4=%h rd=%0d v=%b rw=%b mw=%b, required all 0",
               ALUResult_M, WriteData_M, PCPlus4_M, rd_M, valid_M, RegWrite_M, MemWrite_M);
    end
    @(negedge clk);
    rst_n = 1;
    model_clear();
  endtask

  task automatic test_forwarding();
    logic [1:0]  sels [4] = '{2'b10, 2'b00, 2'b01, 2'b11};
    logic [31:0] want [4] = '{32'd10, 32'd6, 32'd8, 32'd6};
    for (int i = 0; i < 4; i++) begin
      set_idle();
      valid_E = 1; rd1_E = 9; ALUCtrl_E = ALU_ADD;
      tick();
      @(negedge clk);
      rd1_E = 5; rd2_E = 1; Result_W = 7; FwdSel_A = sels[i];
      tick();
      n_tests++;
      if (ALUResult_M !== want[i]) begin
        n_fail++;
        $display("FAIL fwd_sel_%b: got %0d, required %0d", sels[i], ALUResult_M, want[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rvx10_ops();
    logic [4:0]  ops [7] = '{ALU_ROR, ALU_ROL, ALU_ABS, ALU_MIN, ALU_MINU, ALU_ABS, 5'd25};
    logic [31:0] as  [7] = '{32'h8000_0001, 32'h8000_0001, 32'hFFFF_FFFB, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678};
    logic [31:0] bs  [7] = '{32'd1, 32'd0, 32'd7, 32'd1, 32'd1, 32'd3, 32'd5};
    logic [31:0] want[7] = '{32'hC000_0000, 32'h8000_0001, 32'd5, 32'hFFFF_FFFF,
                             32'd1, 32'h8000_0000, 32'd0};
    for (int i = 0; i < 7; i++) begin
      set_idle();
      valid_E = 1; ALUCtrl_E = ops[i]; rd1_E = as[i];
      ALUSrc_E = 1; imm_E = bs[i]; rd2_E = 32'hDEAD_0000 + 32'(i);
      tick();
      n_tests++;
      if (ALUResult_M !== want[i]) begin
        n_fail++;
        $display("FAIL alu_op_%0d: got %h, required %h", ops[i], ALUResult_M, want[i]);
      end
      n_tests++;
      if (WriteData_M !== 32'hDEAD_0000 + 32'(i)) begin
        n_fail++;
        $display("FAIL writedata_op_%0d: got %h, required %h", ops[i], WriteData_M, 32'hDEAD_0000 + 32'(i));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    set_idle();
    valid_E = 1; Branch_E = 1; funct3_E = F3_BLT; rd1_E = 32'hFFFF_FFFE; rd2_E = 3;
    pc_E = 32'h100; imm_E = 32'h20;
    #1;
    n_tests++;
    if (PCSrc_E !== 1'b1 || PCTarget_E !== 32'h120) begin
      n_fail++;
      $display("FAIL blt_taken: pcsrc=%b tgt=%h, required 1 / 00000120", PCSrc_E, PCTarget_E);
    end
    valid_E = 0;
    #1;
    n_tests++;
    if (PCSrc_E !== 1'b0) begin
      n_fail++;
      $display("FAIL blt_bubble: pcsrc=%b, required 0", PCSrc_E);
    end
    valid_E = 1; funct3_E = F3_BLTU; ALUSrc_E = 1; imm_E = 32'hFFFF_FFFF;
    #1;
    n_tests++;
    if (PCSrc_E !== 1'b0) begin
      n_fail++;
      $display("FAIL bltu_not_taken: pcsrc=%b, required 0", PCSrc_E);
    end
    funct3_E = 3'b010; rd2_E = 32'hFFFF_FFFE;
    #1;
    n_tests++;
    if (PCSrc_E !== 1'b0) begin
      n_fail++;
      $display("FAIL f3_010_false: pcsrc=%b, required 0", PCSrc_E);
    end
    @(negedge clk);
  endtask

  task automatic test_jalr();
    set_idle();
    valid_E = 1; Jump_E = 1; Jalr_E = 1; rd1_E = 32'h1003; imm_E = 32'h10; ALUSrc_E = 1;
    pc_E = 32'h200; rd_E = 5'd1; RegWrite_E = 1; ResultSrc_E = 2'b10;
    #1;
    n_tests++;
    if (PCTarget_E !== 32'h1012 || PCSrc_E !== 1'b1) begin
      n_fail++;
      $display("FAIL jalr_target: tgt=%h pcsrc=%b, required 00001012 / 1", PCTarget_E, PCSrc_E);
    end
    tick();
    n_tests++;
    if (PCPlus4_M !== 32'h204 || rd_M !== 5'd1 || RegWrite_M !== 1'b1 || ResultSrc_M !== 2'b10) begin
      n_fail++;
      $display("FAIL jalr_link: pc4=%h rd=%0d rw=%b rs=%b, required 00000204 / 1 / 1 / 10",
               PCPlus4_M, rd_M, RegWrite_M, ResultSrc_M);
    end
    @(negedge clk);
  endtask

  task automatic test_stall_flush();
    set_idle();
    valid_E = 1; rd1_E = 1; rd2_E = 2; rd_E = 5'd3; RegWrite_E = 1; MemWrite_E = 1;
    tick();
    @(negedge clk);
    stall_M = 1; rd1_E = 100; rd2_E = 100; rd_E = 5'd9; pc_E = 32'h40;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_tests++;
      if (ALUResult_M !== 32'd3 || WriteData_M !== 32'd2 || rd_M !== 5'd3 || PCPlus4_M !== 32'd4
          || valid_M !== 1'b1 || MemWrite_M !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: alu=%0d wd=%0d rd=%0d pc4=%h v=%b mw=%b, required 3/2/3/4/1/1",
                 c, ALUResult_M, WriteData_M, rd_M, PCPlus4_M, valid_M, MemWrite_M);
      end
      @(negedge clk);
    end
    FwdSel_A = FWD_MEM; Jalr_E = 1; imm_E = 32'h10;
    #1;
    n_tests++;
    if (PCTarget_E !== 32'h12) begin
      n_fail++;
      $display("FAIL stall_fwd_mem: tgt=%h, required 00000012", PCTarget_E);
    end
    flush_M = 1;
    tick();
    n_tests++;
    if (valid_M !== 1'b0 || RegWrite_M !== 1'b0 || MemWrite_M !== 1'b0 || ALUResult_M !== 32'd0) begin
      n_fail++;
      $display("FAIL flush_over_stall: v=%b rw=%b mw=%b alu=%h, required 0/0/0/0",
               valid_M, RegWrite_M, MemWrite_M, ALUResult_M);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_async();
    set_idle();
    valid_E = 1; rd1_E = 3; rd2_E = 4; rd_E = 5'd7; RegWrite_E = 1; pc_E = 32'h80;
    tick();
    @(negedge clk);
    stall_M = 1;
    tick();
    #2 rst_n = 0;
    #1;
    n_tests++;
    if ({ALUResult_M, WriteData_M, PCPlus4_M, rd_M, ResultSrc_M, valid_M, RegWrite_M, MemWrite_M} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_midstall: alu=%h pc4=%h rd=%0d v=%b rw=%b, required all 0",
               ALUResult_M, PCPlus4_M, rd_M, valid_M, RegWrite_M);
    end
    @(negedge clk);
    rst_n = 1; stall_M = 0; model_clear();
    rd1_E = 10; rd2_E = 20;
    tick();
    n_tests++;
    if (ALUResult_M !== 32'd30 || valid_M !== 1'b1 || PCPlus4_M !== 32'h84) begin
      n_fail++;
      $display("FAIL first_edge_after_reset: alu=%0d v=%b pc4=%h, required 30/1/00000084",
               ALUResult_M, valid_M, PCPlus4_M);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] pool [4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    for (int i = 0; i < 300; i++) begin
      valid_E     = 1'($urandom);
      rd1_E       = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
      rd2_E       = ($urandom_range(0, 3) == 0) ? rd1_E : $urandom;
      imm_E       = $urandom;
      pc_E        = $urandom;
      rd_E        = 5'($urandom);
      ALUCtrl_E   = 5'($urandom);
      ALUSrc_E    = 1'($urandom);
      funct3_E    = 3'($urandom);
      RegWrite_E  = 1'($urandom);
      MemWrite_E  = 1'($urandom);
      Branch_E    = 1'($urandom);
      Jump_E      = ($urandom_range(0, 3) == 0);
      Jalr_E      = 1'($urandom);
      ResultSrc_E = 2'($urandom);
      FwdSel_A    = 2'($urandom);
      FwdSel_B    = 2'($urandom);
      Result_W    = $urandom;
      stall_M     = ($urandom_range(0, 3) == 0);
      flush_M     = ($urandom_range(0, 7) == 0);
      #1;
      n_tests++;
      if (PCSrc_E !== exp_pcsrc() || PCTarget_E !== exp_target()) begin
        n_fail++;
        $display("FAIL rand_comb_%0d: pcsrc=%b tgt=%h, required %b / %h",
                 i, PCSrc_E, PCTarget_E, exp_pcsrc(), exp_target());
      end
      tick();
      n_tests++;
      if (ALUResult_M !== m_alu || WriteData_M !== m_wd || PCPlus4_M !== m_pc4 || rd_M !== m_rd
          || ResultSrc_M !== m_rs || valid_M !== m_valid || RegWrite_M !== m_rw || MemWrite_M !== m_mw) begin
        n_fail++;
        $display("FAIL rand_reg_%0d: got %h %h %h %0d %b %b%b%b, required %h %h %h %0d %b %b%b%b", i,
                 ALUResult_M, WriteData_M, PCPlus4_M, rd_M, ResultSrc_M, valid_M, RegWrite_M, MemWrite_M,
                 m_alu, m_wd, m_pc4, m_rd, m_rs, m_valid, m_rw, m_mw);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_rvx10_ops();
    test_branch();
    test_jalr();
    test_stall_flush();
    test_reset_async();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
